// File: rtl/two_src_mux_arbiter_pkg.sv
// Shared definitions for the two-source round-robin mux arbiter:
// FSM state encoding, mux select encoding and the hold counter width.
package two_src_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Wide enough for the largest legal MAX_HOLD (255).
    localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/two_one_mux.sv
// Gate-level 1-bit 2:1 mux: y = s ? b : a.
module two_one_mux (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    logic s_n;
    logic a_path;
    logic b_path;

    assign s_n    = ~s;
    assign a_path = a & s_n;
    assign b_path = b & s;
    assign y      = a_path | b_path;

endmodule

// File: rtl/two_src_mux_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between two bursting
// requesters A and B, followed by a single registered valid/ready stage.
//
// Handshake: a requester beat moves when its grant, its req and acc_ok are
// all high in the same cycle (acc_ok = stage empty or being drained). The
// output stage presents a beat while out_valid is high; it is consumed on a
// rising edge where out_valid and out_ready are both high. out_valid never
// drops without a transfer, and out_data/out_last stay stable while stalled.
module two_src_mux_arbiter
    import two_src_mux_arbiter_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              last_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              last_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    localparam logic [HOLD_CNT_W-1:0] MAX_HOLD_C = HOLD_CNT_W'(MAX_HOLD);

    arb_state_t              state;
    arb_state_t              next_state;
    logic                    sel_q;
    logic                    last_served;
    logic [HOLD_CNT_W-1:0]   hold_cnt;
    logic [HOLD_CNT_W-1:0]   hold_inc;
    logic [DATA_W-1:0]       mux_data;
    logic                    mux_last;
    logic                    acc_ok;
    logic                    acc_a;
    logic                    acc_b;
    logic                    acc;
    logic                    other_req;
    logic                    release_gnt;

    // Datapath: one gate-level mux per data bit, steered by the registered select.
    for (genvar i = 0; i < DATA_W; i++) begin : g_mux
        two_one_mux u_mux (
            .a (data_a[i]),
            .b (data_b[i]),
            .s (sel_q),
            .y (mux_data[i])
        );
    end

    // Beat accept, saturating hold count and grant release decision.
    always_comb begin
        mux_last    = (sel_q == SEL_B) ? last_b : last_a;
        acc_ok      = ~out_valid | out_ready;
        acc_a       = gnt_a & req_a & acc_ok;
        acc_b       = gnt_b & req_b & acc_ok;
        acc         = acc_a | acc_b;
        other_req   = (state == GNT_B) ? req_a : req_b;
        hold_inc    = (hold_cnt >= MAX_HOLD_C) ? MAX_HOLD_C : hold_cnt + 1'b1;
        // End of burst, or the hold budget is used up while the other side waits.
        release_gnt = acc & (mux_last | ((hold_inc == MAX_HOLD_C) & other_req));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state: round-robin on ties, direct hand-over when the other side waits.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    next_state = (last_served == SEL_B) ? GNT_A : GNT_B;
                end else if (req_a) begin
                    next_state = GNT_A;
                end else if (req_b) begin
                    next_state = GNT_B;
                end
            end
            GNT_A: begin
                if (release_gnt) begin
                    next_state = req_b ? GNT_B : IDLE;
                end
            end
            GNT_B: begin
                if (release_gnt) begin
                    next_state = req_a ? GNT_A : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: grants decode the state register, select comes from its own register.
    always_comb begin
        gnt_a = (state == GNT_A);
        gnt_b = (state == GNT_B);
        sel   = sel_q;
    end

    // Select follows the granted side and holds its last value through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= SEL_A;
        end else if (next_state == GNT_A) begin
            sel_q <= SEL_A;
        end else if (next_state == GNT_B) begin
            sel_q <= SEL_B;
        end
    end

    // Remember who was served last; starts as B so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served <= SEL_B;
        end else if (release_gnt) begin
            last_served <= (state == GNT_B) ? SEL_B : SEL_A;
        end
    end

    // Hold counter: counts accepted beats of the current grant, cleared on grant change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (next_state != state) begin
            hold_cnt <= '0;
        end else if (acc) begin
            hold_cnt <= hold_inc;
        end
    end

    // Output stage: load on accept, drop valid when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_last  <= mux_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_two_src_mux_arbiter.sv
// Directed bench for two_src_mux_arbiter: a per-cycle vector table covering
// fairness, single-source streaming, preemption, backpressure and hold
// saturation, plus hand-written reset sequences and a delivered-beat scoreboard.
module tb_two_src_mux_arbiter;

    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;
    localparam int W        = DATA_W + 1;

    logic              clk;
    logic              rst_n;
    logic              req_a;
    logic [DATA_W-1:0] data_a;
    logic              last_a;
    logic              req_b;
    logic [DATA_W-1:0] data_b;
    logic              last_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic              ra;
        logic [DATA_W-1:0] da;
        logic              la;
        logic              rb;
        logic [DATA_W-1:0] db;
        logic              lb;
        logic              rdy;
        logic              e_ga;
        logic              e_gb;
        logic              e_sel;
        logic              e_ov;
        logic [DATA_W-1:0] e_od;
        logic              e_ol;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];

    two_src_mux_arbiter #(
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .last_a    (last_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .last_b    (last_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ra, input logic [7:0] da, input logic la,
                       input logic rb, input logic [7:0] db, input logic lb,
                       input logic rdy,
                       input logic ga, input logic gb, input logic s,
                       input logic ov, input logic [7:0] od, input logic ol);
        vec_t v;
        v.ra = ra; v.da = da; v.la = la;
        v.rb = rb; v.db = db; v.lb = lb;
        v.rdy = rdy;
        v.e_ga = ga; v.e_gb = gb; v.e_sel = s;
        v.e_ov = ov; v.e_od = od; v.e_ol = ol;
        vecs.push_back(v);
    endtask

    task automatic push_beat(input logic lst, input logic [7:0] d);
        exp_q.push_back({lst, d});
    endtask

    task automatic drive(input logic ra, input logic [7:0] da, input logic la,
                         input logic rb, input logic [7:0] db, input logic lb,
                         input logic rdy);
        req_a = ra; data_a = da; last_a = la;
        req_b = rb; data_b = db; last_b = lb;
        out_ready = rdy;
    endtask

    task automatic check_outputs(input string tag, input logic ga, input logic gb,
                                 input logic s, input logic ov,
                                 input logic [7:0] od, input logic ol, input logic chk_ol);
        check({tag, " gnt_a"},     gnt_a,     ga);
        check({tag, " gnt_b"},     gnt_b,     gb);
        check({tag, " gnt_excl"},  gnt_a & gnt_b, 1'b0);
        check({tag, " sel"},       sel,       s);
        check({tag, " out_valid"}, out_valid, ov);
        check({tag, " out_data"},  out_data,  od);
        if (chk_ol) check({tag, " out_last"}, out_last, ol);
    endtask

    // Scoreboard: every beat transferred downstream must match the expected order.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_extra: got beat 0x%0h, expected none", {out_last, out_data});
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    tests_failed++;
                    $display("FAIL sb_beat: got 0x%0h, expected 0x%0h", {out_last, out_data}, e);
                end
            end
        end
    end

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        rst_n = 1'b0;

        // Fairness: both sides with 2-beat bursts, A wins the first tie.
        add(1,8'hA1,0, 1,8'hB1,0, 1,  1,0,0, 0,8'h00,0);
        add(1,8'hA1,0, 1,8'hB1,0, 1,  1,0,0, 1,8'hA1,0);
        add(1,8'hA2,1, 1,8'hB1,0, 1,  0,1,1, 1,8'hA2,1);
        add(1,8'hA3,0, 1,8'hB1,0, 1,  0,1,1, 1,8'hB1,0);
        add(1,8'hA3,0, 1,8'hB2,1, 1,  1,0,0, 1,8'hB2,1);
        add(1,8'hA3,0, 1,8'hB3,0, 1,  1,0,0, 1,8'hA3,0);
        add(1,8'hA4,1, 1,8'hB3,0, 1,  0,1,1, 1,8'hA4,1);
        add(0,8'h00,0, 1,8'hB3,0, 1,  0,1,1, 1,8'hB3,0);
        add(0,8'h00,0, 1,8'hB4,1, 1,  0,0,1, 1,8'hB4,1);
        add(0,8'h00,0, 0,8'h00,0, 1,  0,0,1, 0,8'hB4,0);
        // Single-source streaming.
        add(1,8'h11,0, 0,8'h00,0, 1,  1,0,0, 0,8'hB4,0);
        add(1,8'h11,0, 0,8'h00,0, 1,  1,0,0, 1,8'h11,0);
        add(1,8'h22,0, 0,8'h00,0, 1,  1,0,0, 1,8'h22,0);
        add(1,8'h33,1, 0,8'h00,0, 1,  0,0,0, 1,8'h33,1);
        add(0,8'h00,0, 0,8'h00,0, 1,  0,0,0, 0,8'h33,0);
        // Preemption: 6-beat A burst, B waiting from A's 2nd beat.
        add(1,8'h01,0, 0,8'h00,0, 1,  1,0,0, 0,8'h33,0);
        add(1,8'h01,0, 0,8'h00,0, 1,  1,0,0, 1,8'h01,0);
        add(1,8'h02,0, 1,8'hC1,0, 1,  1,0,0, 1,8'h02,0);
        add(1,8'h03,0, 1,8'hC1,0, 1,  1,0,0, 1,8'h03,0);
        add(1,8'h04,0, 1,8'hC1,0, 1,  0,1,1, 1,8'h04,0);
        add(1,8'h05,0, 1,8'hC1,0, 1,  0,1,1, 1,8'hC1,0);
        add(1,8'h05,0, 1,8'hC2,1, 1,  1,0,0, 1,8'hC2,1);
        add(1,8'h05,0, 0,8'h00,0, 1,  1,0,0, 1,8'h05,0);
        add(1,8'h06,1, 0,8'h00,0, 1,  0,0,0, 1,8'h06,1);
        add(0,8'h00,0, 0,8'h00,0, 1,  0,0,0, 0,8'h06,0);
        // Backpressure for 3 cycles mid-burst; stalls must not count toward the hold.
        add(1,8'h31,0, 0,8'h00,0, 1,  1,0,0, 0,8'h06,0);
        add(1,8'h31,0, 0,8'h00,0, 1,  1,0,0, 1,8'h31,0);
        add(1,8'h32,0, 0,8'h00,0, 0,  1,0,0, 1,8'h31,0);
        add(1,8'h32,0, 1,8'hD1,1, 0,  1,0,0, 1,8'h31,0);
        add(1,8'h32,0, 1,8'hD1,1, 0,  1,0,0, 1,8'h31,0);
        add(1,8'h32,0, 1,8'hD1,1, 1,  1,0,0, 1,8'h32,0);
        add(1,8'h33,0, 1,8'hD1,1, 1,  1,0,0, 1,8'h33,0);
        add(1,8'h34,0, 1,8'hD1,1, 1,  0,1,1, 1,8'h34,0);
        add(1,8'h35,1, 1,8'hD1,1, 1,  1,0,0, 1,8'hD1,1);
        add(1,8'h35,1, 0,8'h00,0, 1,  0,0,0, 1,8'h35,1);
        add(0,8'h00,0, 0,8'h00,0, 1,  0,0,0, 0,8'h35,0);
        // Saturated hold with B idle; a late B request releases on the next beat.
        add(1,8'h41,0, 0,8'h00,0, 1,  1,0,0, 0,8'h35,0);
        add(1,8'h41,0, 0,8'h00,0, 1,  1,0,0, 1,8'h41,0);
        add(1,8'h42,0, 0,8'h00,0, 1,  1,0,0, 1,8'h42,0);
        add(1,8'h43,0, 0,8'h00,0, 1,  1,0,0, 1,8'h43,0);
        add(1,8'h44,0, 0,8'h00,0, 1,  1,0,0, 1,8'h44,0);
        add(1,8'h45,0, 0,8'h00,0, 1,  1,0,0, 1,8'h45,0);
        add(1,8'h46,0, 1,8'hE1,1, 1,  0,1,1, 1,8'h46,0);
        add(1,8'h47,1, 1,8'hE1,1, 1,  1,0,0, 1,8'hE1,1);
        add(1,8'h47,1, 0,8'h00,0, 1,  0,0,0, 1,8'h47,1);
        add(0,8'h00,0, 0,8'h00,0, 1,  0,0,0, 0,8'h47,0);

        push_beat(0,8'hA1); push_beat(1,8'hA2); push_beat(0,8'hB1); push_beat(1,8'hB2);
        push_beat(0,8'hA3); push_beat(1,8'hA4); push_beat(0,8'hB3); push_beat(1,8'hB4);
        push_beat(0,8'h11); push_beat(0,8'h22); push_beat(1,8'h33);
        push_beat(0,8'h01); push_beat(0,8'h02); push_beat(0,8'h03); push_beat(0,8'h04);
        push_beat(0,8'hC1); push_beat(1,8'hC2); push_beat(0,8'h05); push_beat(1,8'h06);
        push_beat(0,8'h31); push_beat(0,8'h32); push_beat(0,8'h33); push_beat(0,8'h34);
        push_beat(1,8'hD1); push_beat(1,8'h35);
        push_beat(0,8'h41); push_beat(0,8'h42); push_beat(0,8'h43); push_beat(0,8'h44);
        push_beat(0,8'h45); push_beat(0,8'h46); push_beat(1,8'hE1); push_beat(1,8'h47);

        // Reset state, visible without any clock edge.
        #1;
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].ra, vecs[i].da, vecs[i].la, vecs[i].rb, vecs[i].db, vecs[i].lb,
                  vecs[i].rdy);
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i].e_ga, vecs[i].e_gb, vecs[i].e_sel,
                          vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ol, vecs[i].e_ov);
        end

        // Reset mid-burst: B streaming with a beat in the stage, then async reset.
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hF1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_outputs("rst_pre_gnt", 1'b0, 1'b1, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("rst_pre_beat", 1'b0, 1'b1, 1'b1, 1'b1, 8'hF1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // After reset, a tie must go to A again.
        @(negedge clk);
        drive(1'b1, 8'h51, 1'b0, 1'b1, 8'h61, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_outputs("rst_tie", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
